// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte path between NREQ requesters.
// Grants are held until a last byte, a burst limit or request withdrawal, then an idle gap follows.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int n        = 8,
  parameter int MAXBURST = 16,
  parameter int GAP      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*n-1:0]       data_i,
  input  logic [NREQ-1:0]         last_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy_o,
  output logic [n-1:0]            tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i
);
  localparam int OW = $clog2(NREQ);
  localparam logic [OW:0]   NREQ_V = (OW+1)'(NREQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(NREQ-1);
  localparam logic [7:0]    MB = 8'(MAXBURST);
  localparam logic [3:0]    GAP_LD = 4'((GAP > 0) ? GAP-1 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, GAPW} state_t;

  state_t                 state, state_nxt;
  logic [OW-1:0]          owner, owner_nxt, ptr, ptr_nxt, hit;
  logic [7:0]             cnt, cnt_nxt;
  logic [3:0]             gcnt, gcnt_nxt;
  logic                   found, xfer, rel;
  logic [2*NREQ-1:0]      req_rot;
  logic [OW:0]            hit_sum;
  logic [NREQ-1:0][n-1:0] lane_data;

  assign lane_data = data_i;
  assign req_rot   = {req_i, req_i} >> ptr;

  // Walk downward so the smallest offset from ptr is the one that sticks.
  always_comb begin
    found   = 1'b0;
    hit_sum = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found   = 1'b1;
        hit_sum = {1'b0, ptr} + (OW+1)'(i);
      end
    end
    hit = (hit_sum >= NREQ_V) ? OW'(hit_sum - NREQ_V) : OW'(hit_sum);
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    xfer      = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = hit;
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        xfer = req_i[owner] & tx_ready_i;
        if (xfer) cnt_nxt = cnt + 8'd1;
        // last byte and burst limit on the same transfer collapse into one release
        rel = ~req_i[owner] | (xfer & (last_i[owner] | (cnt_nxt == MB)));
        if (rel) begin
          ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          gcnt_nxt  = GAP_LD;
          state_nxt = (GAP == 0) ? IDLE : GAPW;
        end
      end
      GAPW: begin
        if (gcnt == '0) state_nxt = IDLE;
        else            gcnt_nxt  = gcnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  // Outputs are forced quiet during the reset cycle so an in-flight byte is never acked.
  always_comb begin
    ack_o      = '0;
    grant_o    = '0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    if (state == STREAM && !rst_i) begin
      grant_o[owner] = 1'b1;
      tx_valid_o     = req_i[owner];
      tx_data_o      = lane_data[owner];
      ack_o[owner]   = xfer;
    end
  end

  assign busy_o  = (state != IDLE) & ~rst_i;
  assign owner_o = rst_i ? '0 : owner;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmit byte path between NREQ requesters (host write port, RX echo path, status reporter, etc.).
- Grants one requester at a time and forwards its bytes to the transmitter's valid/ready input until one of three events: a byte marked last, a MAXBURST byte limit, or withdrawal of the request.
- Inserts a programmable idle gap between grants so the receiver can resynchronise on frame boundaries.

Parameters:
- NREQ, 4, number of requesters (2..8).
- n, 8, data byte width.
- MAXBURST, 16, maximum bytes per grant (1..255).
- GAP, 2, idle cycles between release and the next arbitration (0..15).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  NREQ  per-requester byte available; bit k is valid for data_i slice k.
- data_i  input  NREQ*n  packed bytes; requester k occupies bits [k*n +: n].
- last_i  input  NREQ  the byte presented by requester k is the final byte of its packet.
- ack_o  output  NREQ  one-hot pulse: requester k's byte was accepted this cycle.
- grant_o  output  NREQ  one-hot current owner; all zero when no owner.
- owner_o  output  clog2(NREQ)  index of the current or most recent owner.
- busy_o  output  1  high in STREAM and GAP.
- tx_data_o  output  n  byte to the transmitter.
- tx_valid_o  output  1  byte valid to the transmitter.
- tx_ready_i  input  1  transmitter accepts a byte; transfer = tx_valid_o & tx_ready_i.

Behaviour:
- Reset state: every output is 0. State=IDLE, round-robin pointer ptr=0, burst count cnt=0, gap counter=0. Reset during STREAM drops the grant immediately; the partially sent packet is abandoned and no ack is issued in the reset cycle.
- State IDLE:
  - Search req_i starting at index ptr, wrapping modulo NREQ.
  - If any bit is set, register owner=first hit, set grant_o one-hot, cnt=0, next state STREAM.
  - If no bit is set, stay in IDLE.
- State STREAM (combinational path from inputs to tx outputs):
  - tx_valid_o = req_i[owner].
  - tx_data_o = data_i[owner*n +: n].
  - ack_o[owner] = transfer; other ack bits are 0.
  - On each transfer, cnt increments.
- Release from STREAM: taken at the clock edge after any of:
  - (a) a transfer with last_i[owner]=1;
  - (b) a transfer that brings cnt to MAXBURST;
  - (c) req_i[owner]=0 in that cycle (abandon, no transfer).
- On release:
  - grant_o is cleared.
  - ptr becomes (owner+1) mod NREQ.
  - Next state is GAP with the counter loaded to GAP-1, or IDLE directly if GAP=0.
- Simultaneous (a) and (b) count as a single release.
- tx_ready_i high while tx_valid_o is low has no effect.
- State GAP: lasts exactly GAP cycles. tx_valid_o=0, ack_o=0, busy_o=1. Then IDLE.
- Latency:
  - A request arriving in IDLE at cycle k gives grant_o at k+1; the first transfer is possible at k+1.
  - A final transfer at cycle t gives GAP cycles t+1..t+GAP, IDLE at t+GAP+1, and the earliest new grant at t+GAP+2.
- Fairness: a requester that keeps req_i high is served at most MAXBURST bytes per grant. Every other asserted requester is granted before it returns (at most NREQ-1 intervening grants).
- owner_o holds its value through GAP and IDLE until the next grant.
- No output depends on tx_ready_i except ack_o.
- data_i and last_i of requesters without the grant are ignored.

Test Plan:
- Single requester:
  - Stimulus: after reset, req_i=4'b0010; bytes 0x41,0x42,0x43 with last_i[1] on 0x43; tx_ready_i=1.
  - Required: grant_o=0010 one cycle after req; three acks on ack_o[1]; tx_data_o sequence 41,42,43; GAP=2 idle cycles; ptr=2.
- Round-robin:
  - Stimulus: req_i=4'b1111 held; each requester sends 1-byte packets with last_i=1.
  - Required: grant order 0,1,2,3,0; each grant separated by 2 GAP cycles plus 1 IDLE cycle.
- Burst limit:
  - Stimulus: MAXBURST=16; requester 2 streams 40 bytes with no last; requester 0 also requesting.
  - Required: requester 2 gets 16 acks; grant passes to requester 0; requester 2 is re-granted afterwards and receives bytes 17..32 in order.
- Backpressure:
  - Stimulus: tx_ready_i toggles 1,0,0,1 during a 2-byte packet.
  - Required: tx_data_o holds the byte stable while tx_ready_i=0; exactly 2 ack pulses; no duplicate bytes.
- Abandon:
  - Stimulus: the owner drops req_i after 1 byte.
  - Required: release at the next edge; busy_o stays high for GAP cycles; then the next requester is granted.
- Reset mid-stream:
  - Stimulus: rst_i=1 during the 3rd byte of a 5-byte packet with tx_ready_i=1.
  - Required: no ack in that cycle; all outputs 0 the next cycle; after release of rst_i, requester 0 has priority (ptr=0).
